// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: streams WORDS words of WIDTH bits through one
// ripple adder, LSW first, chaining the carry between cycles.

module adder #(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    logic [WIDTH:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = cin_i;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = c[WIDTH];
    end
endmodule

module adder_seq_ctrl #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] A,
    input  logic [WIDTH*WORDS-1:0] B,
    input  logic                   Cin,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] Sum,
    output logic                   Cout,
    output logic                   Ovf,
    output logic                   busy
);
    localparam int unsigned TW   = WIDTH * WORDS;
    localparam int unsigned IdxW = $clog2(WORDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [TW-1:0]   a_q;
    logic [TW-1:0]   b_q;
    logic            carry_q;
    logic [IdxW-1:0] idx_q;
    logic [TW-1:0]   sum_q;
    logic            cout_q;
    logic            ovf_q;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    assign add_a = a_q[int'(idx_q)*WIDTH +: WIDTH];
    assign add_b = b_q[int'(idx_q)*WIDTH +: WIDTH];

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= A;
                        // Subtract is A + ~B + 1, so B is stored pre-inverted.
                        b_q     <= sub ? ~B : B;
                        carry_q <= sub | Cin;
                        idx_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sum_q[int'(idx_q)*WIDTH +: WIDTH] <= add_sum;
                    carry_q <= add_cout;
                    idx_q   <= idx_q + IdxW'(1);
                    if (idx_q == LastIdx) begin
                        cout_q  <= add_cout;
                        ovf_q   <= (a_q[TW-1] == b_q[TW-1]) && (add_sum[WIDTH-1] != a_q[TW-1]);
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: vector table, hand-written corner sequences and a random
// back-to-back run, all scored against a queue of model results.

module tb_adder_seq_ctrl;
    localparam int WIDTH = 6;
    localparam int WORDS = 4;
    localparam int TW    = WIDTH * WORDS;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] A;
    logic [TW-1:0] B;
    logic          Cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] Sum;
    logic          Cout;
    logic          Ovf;
    logic          busy;

    adder_seq_ctrl #(
        .WIDTH (WIDTH),
        .WORDS (WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic          cin;
        logic          sub;
        logic [TW-1:0] sum;
        logic          cout;
        logic          ovf;
    } vec_t;

    typedef struct {
        logic [TW-1:0] sum;
        logic          cout;
        logic          ovf;
    } res_t;

    vec_t vecs[9];
    res_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_acc = -1;
    int   n_acc   = 0;
    bit   b2b_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                   input logic cin, input logic s);
        res_t          r;
        logic [TW-1:0] bm;
        logic [TW:0]   full;
        bm     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bm} + {{TW{1'b0}}, (s | cin)};
        r.sum  = full[TW-1:0];
        r.cout = full[TW];
        r.ovf  = (a[TW-1] == bm[TW-1]) && (r.sum[TW-1] != a[TW-1]);
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        res_t r;
        if (!rst && in_valid && in_ready) begin
            sb.push_back(model(A, B, Cin, sub));
            if (b2b_mode) begin
                if (last_acc >= 0) chk("b2b_interval", 64'(cyc - last_acc), 64'(WORDS + 2));
                last_acc = cyc;
                n_acc++;
            end
        end
        if (!rst && out_valid && out_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                r = sb.pop_front();
                chk("sb_sum", 64'(Sum), 64'(r.sum));
                chk("sb_cout", 64'(Cout), 64'(r.cout));
                chk("sb_ovf", 64'(Ovf), 64'(r.ovf));
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns once out_valid is seen (or bound expires).
    task automatic do_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                         input logic s, output int lat);
        in_valid = 1'b1;
        A = a;
        B = b;
        Cin = cin;
        sub = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("done_seen", 64'(out_valid), 64'd1);
    endtask

    initial begin
        int            lat;
        logic [TW-1:0] hold_sum;
        logic          hold_cout;
        logic          hold_ovf;

        vecs[0] = '{24'h00003F, 24'h000001, 1'b0, 1'b0, 24'h000040, 1'b0, 1'b0};
        vecs[1] = '{24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0};
        vecs[2] = '{24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1};
        vecs[3] = '{24'h000000, 24'h000001, 1'b1, 1'b1, 24'hFFFFFF, 1'b0, 1'b0};
        vecs[4] = '{24'h800000, 24'h000001, 1'b0, 1'b1, 24'h7FFFFF, 1'b1, 1'b1};
        vecs[5] = '{24'h123456, 24'h654321, 1'b1, 1'b0, 24'h777778, 1'b0, 1'b0};
        vecs[6] = '{24'h000005, 24'h000005, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b0};
        vecs[7] = '{24'h800000, 24'h800000, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1};
        vecs[8] = '{24'h000000, 24'h000000, 1'b1, 1'b0, 24'h000001, 1'b0, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        Cin = 1'b0;
        sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", 64'(Sum), 64'd0);
        chk("rst_cout", 64'(Cout), 64'd0);
        chk("rst_ovf", 64'(Ovf), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            if (i == 0) chk("latency", 64'(lat), 64'(WORDS + 1));
            chk("vec_sum", 64'(Sum), 64'(vecs[i].sum));
            chk("vec_cout", 64'(Cout), 64'(vecs[i].cout));
            chk("vec_ovf", 64'(Ovf), 64'(vecs[i].ovf));
            @(posedge clk);
            #1;
            chk("vec_back_idle", 64'(in_ready), 64'd1);
        end

        // Backpressure: result must hold and new operands must be refused.
        out_ready = 1'b0;
        do_op(24'hFFFFFF, 24'h800000, 1'b0, 1'b0, lat);
        hold_sum  = Sum;
        hold_cout = Cout;
        hold_ovf  = Ovf;
        chk("bp_sum", 64'(hold_sum), 64'h7FFFFF);
        chk("bp_flags", 64'({hold_cout, hold_ovf}), 64'd3);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            A = 24'h000111;
            B = 24'h000222;
            @(posedge clk);
            #1;
            chk("bp_hold_sum", 64'(Sum), 64'(hold_sum));
            chk("bp_hold_flags", 64'({Cout, Ovf}), 64'({hold_cout, hold_ovf}));
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Reset asserted during the second RUN cycle discards the operation.
        in_valid = 1'b1;
        A = 24'hFFFFFF;
        B = 24'hFFFFFF;
        Cin = 1'b1;
        sub = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_sum", 64'(Sum), 64'd0);
        rst = 1'b0;
        do_op(24'h000010, 24'h000020, 1'b0, 1'b0, lat);
        chk("post_rst_sum", 64'(Sum), 64'h000030);
        chk("post_rst_cout", 64'(Cout), 64'd0);
        @(posedge clk);
        #1;

        // Back-to-back random traffic with both handshakes held high.
        b2b_mode = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 1000 * (WORDS + 2) + 50 && n_acc < 1000; c++) begin
            A = TW'($urandom());
            B = TW'($urandom());
            Cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        b2b_mode = 1'b0;
        chk("b2b_accepts", 64'(n_acc), 64'd1000);
        repeat (WORDS + 4) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Multi-precision add/subtract sequencer. Accepts two WIDTH*WORDS-bit operands over a valid/ready handshake and time-multiplexes them through one instance of the team's WIDTH-bit ripple adder (`adder`, parameter WIDTH), one word per cycle, LSW first. The carry is chained between cycles. The block sits between an operand producer and a result consumer, trading latency for area on wide arithmetic.

Parameters:
WIDTH, 6, word width; passed to the internal `adder` instance.
WORDS, 4, number of words per operand; must be at least 2. Total operand width is TW = WIDTH*WORDS.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operand set offered.
in_ready  output  1  block can accept operands (IDLE only).
A  input  TW  operand A, unsigned or two's complement.
B  input  TW  operand B.
Cin  input  1  carry-in for add; ignored for subtract.
sub  input  1  0 = A+B+Cin; 1 = A-B, computed as A+~B+1.
out_valid  output  1  result held valid.
out_ready  input  1  consumer accepts the result.
Sum  output  TW  result, registered.
Cout  output  1  final carry-out; for subtract, 1 means no borrow.
Ovf  output  1  signed overflow of the TW-bit operation.
busy  output  1  high in RUN and DONE.

Behaviour:
- One clock. Reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: state=IDLE, Sum=0, Cout=0, Ovf=0, out_valid=0, busy=0, in_ready=1. Internal word index and carry are cleared to 0.
- FSM states: IDLE, RUN, DONE. in_ready is 1 in IDLE only. out_valid is 1 in DONE only. Both are decoded from state.
- IDLE, on in_valid=1 (handshake fires):
  - Register A into a_r.
  - Register B into b_r, or ~B when sub=1.
  - Register carry_r = sub ? 1 : Cin.
  - Set idx=0 and go to RUN.
  - in_valid is ignored in every state other than IDLE.
- RUN, each cycle:
  - Adder inputs: a_r word idx, b_r word idx, carry_r.
  - Sum word idx <= adder sum; carry_r <= adder carry-out; idx <= idx+1.
  - When idx==WORDS-1: Cout <= adder carry-out; Ovf <= (a_msb==b_msb) && (sum_msb!=a_msb), where b_msb is the effective (possibly inverted) bit TW-1 of b_r. Then go to DONE.
- DONE: Sum, Cout and Ovf are held stable. On out_ready=1, go to IDLE. The output handshake completes in the same cycle that out_ready is seen.
- Latency: the handshake in cycle 0 gives RUN in cycles 1..WORDS and out_valid=1 from cycle WORDS+1. Minimum issue interval is WORDS+2 cycles; there is no input/output overlap.
- Sum words not yet written in RUN keep their previous values. Sum is only defined when out_valid=1.
- out_ready while not in DONE has no effect.
- rst at any time, including mid-RUN or in DONE: return to the reset values on the next edge. The partial result is discarded and no out_valid pulse occurs.
- Width rules: the carry-out of word WORDS-1 is the only carry exported. All arithmetic is modulo 2^TW.

Test Plan:
1. WIDTH=6, WORDS=4. A=0x00003F, B=0x000001, Cin=0, sub=0 -> Sum=0x000040, Cout=0, Ovf=0. The carry crosses the word 0->1 boundary, and out_valid rises exactly 5 cycles after the input handshake.
2. A=0xFFFFFF, B=0x000001, sub=0 -> Sum=0x000000, Cout=1, Ovf=0. Also A=0x7FFFFF, B=0x000001 -> Sum=0x800000, Cout=0, Ovf=1.
3. Subtract: A=0x000000, B=0x000001, sub=1, Cin=1 -> Sum=0xFFFFFF, Cout=0 (borrow), Ovf=0. Also A=0x800000, B=0x000001, sub=1 -> Sum=0x7FFFFF, Ovf=1.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE -> Sum, Cout, Ovf and out_valid stable, in_ready=0, and an in_valid pulse meanwhile is not accepted. Raising out_ready gives IDLE and in_ready=1 on the next cycle.
5. Reset mid-operation: assert rst in the 2nd RUN cycle -> next cycle state=IDLE, Sum=0, out_valid=0, in_ready=1. A following op A=0x000010, B=0x000020 -> Sum=0x000030 with no stale carry.
6. Back-to-back ops with out_ready tied 1 and in_valid tied 1 -> one accept every WORDS+2=6 cycles. Random operands (1000 ops, sub random) match a reference model for Sum, Cout and Ovf.
